// File: rtl/qos_stream_packet_arbiter_if.sv
// Stream bundle between the per-stream input FIFOs, the arbiter and the
// single downstream consumer. The master side drives the sources and m_ready;
// the slave side is the arbiter.
interface qos_stream_packet_arbiter_if #(
  parameter int STREAM_COUNT  = 2,
  parameter int T_DATA__WIDTH = 8,
  parameter int T_QOS__WIDTH  = 4,
  parameter int T_ID___WIDTH  = $clog2(STREAM_COUNT)
) ();
  logic [STREAM_COUNT-1:0]                    s_valid;
  logic [STREAM_COUNT-1:0][T_DATA__WIDTH-1:0] s_data;
  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0]  s_qos;
  logic [STREAM_COUNT-1:0]                    s_last;
  logic [STREAM_COUNT-1:0]                    s_ready;
  logic                                       m_valid;
  logic [T_DATA__WIDTH-1:0]                   m_data;
  logic [T_QOS__WIDTH-1:0]                    m_qos;
  logic                                       m_last;
  logic [T_ID___WIDTH-1:0]                    m_id;
  logic                                       m_ready;

  modport master (
    output s_valid, s_data, s_qos, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_qos, m_last, m_id
  );

  modport slave (
    input  s_valid, s_data, s_qos, s_last, m_ready,
    output s_ready, m_valid, m_data, m_qos, m_last, m_id
  );
endinterface

// File: rtl/qos_stream_packet_arbiter.sv
// Packet-level N:1 stream mux. In IDLE the highest-QoS valid source wins
// (round-robin among equals, starting at rr_ptr); the grant is then locked
// and the granted stream passes straight through until its last beat is taken.
module qos_stream_packet_arbiter #(
  parameter int STREAM_COUNT  = 2,
  parameter int T_DATA__WIDTH = 8,
  parameter int T_QOS__WIDTH  = 4,
  parameter int T_ID___WIDTH  = $clog2(STREAM_COUNT)
) (
  input logic                          clk,
  input logic                          rst,
  qos_stream_packet_arbiter_if.slave   bus
);
  localparam logic [T_ID___WIDTH:0]   N_W     = (T_ID___WIDTH+1)'(STREAM_COUNT);
  localparam logic [T_ID___WIDTH-1:0] LAST_ID = T_ID___WIDTH'(STREAM_COUNT-1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state;
  logic [T_ID___WIDTH-1:0]  rr_ptr;
  logic [T_ID___WIDTH-1:0]  grant_idx;
  logic [T_QOS__WIDTH-1:0]  qos_r;
  logic [T_QOS__WIDTH-1:0]  max_qos;
  logic [STREAM_COUNT-1:0]  cand;
  logic [T_ID___WIDTH-1:0]  winner;
  logic                     found;
  logic [T_ID___WIDTH:0]    sum;
  logic [T_ID___WIDTH-1:0]  idx;
  logic                     in_burst;
  logic                     hs_last;

  // highest QoS among the currently valid requesters (0 when none / all zero)
  always_comb begin
    max_qos = '0;
    for (int i = 0; i < STREAM_COUNT; i++)
      if (bus.s_valid[T_ID___WIDTH'(i)] && bus.s_qos[T_ID___WIDTH'(i)] > max_qos)
        max_qos = bus.s_qos[T_ID___WIDTH'(i)];
  end

  // per-stream: candidate if valid and at the max QoS; ready only for the granted stream
  for (genvar g = 0; g < STREAM_COUNT; g++) begin : g_lane
    assign cand[g]        = bus.s_valid[g] && (bus.s_qos[g] == max_qos);
    assign bus.s_ready[g] = in_burst && (grant_idx == T_ID___WIDTH'(g)) && bus.m_ready;
  end

  // first candidate scanning cyclically from rr_ptr
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < STREAM_COUNT; k++) begin
      sum = {1'b0, rr_ptr} + (T_ID___WIDTH+1)'(k);
      if (sum >= N_W) sum = sum - N_W;
      idx = sum[T_ID___WIDTH-1:0];
      if (!found && cand[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign in_burst    = (state == BURST);
  assign bus.m_valid = in_burst && bus.s_valid[grant_idx];
  assign bus.m_data  = in_burst ? bus.s_data[grant_idx] : '0;
  assign bus.m_last  = in_burst && bus.s_last[grant_idx];
  assign bus.m_qos   = qos_r;
  assign bus.m_id    = grant_idx;
  assign hs_last     = bus.m_valid && bus.m_ready && bus.m_last;

  // arbitration FSM: grant in IDLE, hold until the last beat handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      qos_r     <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant_idx <= winner;
          qos_r     <= bus.s_qos[winner];
          state     <= BURST;
        end
        BURST: if (hs_last) begin
          rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qos_stream_packet_arbiter.sv
// Random sources with packet/valid gaps, random qos and random backpressure,
// checked every cycle against a packet-level model of the arbitration rules.
module tb_qos_stream_packet_arbiter;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int QW = 4;
  localparam int IW = 2;
  localparam int CYCLES = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qos_stream_packet_arbiter_if #(.STREAM_COUNT(N), .T_DATA__WIDTH(DW),
    .T_QOS__WIDTH(QW), .T_ID___WIDTH(IW)) bus ();

  qos_stream_packet_arbiter #(.STREAM_COUNT(N), .T_DATA__WIDTH(DW),
    .T_QOS__WIDTH(QW), .T_ID___WIDTH(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // source state: next sequence number and beats remaining in current packet
  int seq[N];
  int left[N];
  // model state: owner=-1 means no grant held
  int owner;
  int ptr;
  int exp_seq[N];
  logic [QW-1:0] exp_qos;
  logic [IW-1:0] exp_id;

  function automatic logic [DW-1:0] enc(input int i, input int s);
    logic [1:0] a;
    logic [5:0] b;
    a = 2'(i);
    b = 6'(s);
    return {a, b};
  endfunction

  // highest qos wins; among equals the first met walking from ptr
  function automatic int pick();
    int w = -1;
    int best = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (bus.s_valid[IW'(i)] && int'(bus.s_qos[IW'(i)]) > best) begin
        best = int'(bus.s_qos[IW'(i)]);
        w = i;
      end
    end
    return w;
  endfunction

  // advance each source: retire accepted beat, maybe present next one, jitter qos
  task automatic drive(input logic [N-1:0] acc);
    for (int i = 0; i < N; i++) begin
      logic [IW-1:0] x;
      x = IW'(i);
      if (acc[x]) begin
        seq[i]++;
        left[i]--;
        bus.s_valid[x] = 1'b0;
        bus.s_last[x]  = 1'b0;
      end
      if (!bus.s_valid[x] && $urandom_range(0, 3) != 0) begin
        if (left[i] == 0) left[i] = $urandom_range(1, 4);
        bus.s_valid[x] = 1'b1;
        bus.s_data[x]  = enc(i, seq[i]);
        bus.s_last[x]  = (left[i] == 1);
      end
      if ($urandom_range(0, 3) == 0) bus.s_qos[x] = QW'($urandom_range(0, 2) * 7);
    end
  endtask

  initial begin
    logic [N-1:0]  ers;
    logic [N-1:0]  acc;
    logic          emv;
    logic          eml;
    logic [DW-1:0] emd;
    logic [IW-1:0] oi;
    int            w;

    rst = 1'b1;
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.s_qos   = '0;
    bus.s_last  = '0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; left[i] = 0; exp_seq[i] = 0;
    end
    owner = -1; ptr = 0; exp_qos = '0; exp_id = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_m_qos",   32'(bus.m_qos),   32'd0);
    chk("rst_m_id",    32'(bus.m_id),    32'd0);
    chk("rst_m_data",  32'(bus.m_data),  32'd0);
    chk("rst_m_last",  32'(bus.m_last),  32'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    drive('0);
    bus.m_ready = 1'b1;

    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      ers = '0; emv = 1'b0; eml = 1'b0; emd = '0; oi = '0;
      if (owner >= 0) begin
        oi  = IW'(owner);
        emv = bus.s_valid[oi];
        eml = bus.s_last[oi];
        emd = bus.s_data[oi];
        if (bus.m_ready) ers[oi] = 1'b1;
      end
      chk("m_valid", 32'(bus.m_valid), 32'(emv));
      chk("m_last",  32'(bus.m_last),  32'(eml));
      chk("m_data",  32'(bus.m_data),  32'(emd));
      chk("s_ready", 32'(bus.s_ready), 32'(ers));
      chk("m_qos",   32'(bus.m_qos),   32'(exp_qos));
      chk("m_id",    32'(bus.m_id),    32'(exp_id));

      acc = ers & bus.s_valid;
      if (emv && bus.m_ready) begin
        chk("order", 32'(bus.m_data), 32'(enc(owner, exp_seq[owner])));
        exp_seq[owner]++;
      end

      if (rst) begin
        owner = -1; ptr = 0; exp_qos = '0; exp_id = '0;
      end else if (owner < 0) begin
        w = pick();
        if (w >= 0) begin
          owner = w;
          exp_id = IW'(w);
          exp_qos = bus.s_qos[IW'(w)];
        end
      end else if (emv && bus.m_ready && eml) begin
        ptr = (owner + 1) % N;
        owner = -1;
      end

      @(posedge clk); #1;
      drive(acc);
      bus.m_ready = (c % 200 > 150) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 4) != 0);
      rst = ($urandom_range(0, 399) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
